fx3_bus_out_path_mc: RTL and testbench
======================================

Name: fx3_bus_out_path_mc

Overview:
Multi-channel, width-parameterised successor of the FX3 output path. It drains one of N_CHANNELS upstream ping-pong FIFO read sides, selected per transfer, into the FX3 GPIF write interface, segmented into host packets of i_packet_size words. Over the single-channel path it adds:
- per-transfer channel select;
- stall on i_fpga2mcu_ch_rdy low mid-packet;
- programmable inter-packet latency;
- optional zero-length packet (ZLP) when a transfer ends exactly on a packet boundary.

It sits between the core read-data FIFOs and the FX3 bus pins.

Parameters:
DATA_WIDTH, 32, FX3 bus and FIFO word width
N_CHANNELS, 2, number of upstream ping-pong FIFO read sides (1..8)
CH_W, 1, width of channel index; must satisfy 2**CH_W >= N_CHANNELS
STATUS_LENGTH, 3, status words added to every transfer
ZLP_EN, 1, 1 = emit ZLP when transfer total is a nonzero multiple of the packet size
PACKET_MAX, 512, packet size used when i_packet_size == 0

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  asynchronous, active-low reset; assert async, deassert sync to clk
i_in_path_idle  in  1  input path idle; a new packet may start only when 1
i_packet_size  in  24  words per host packet
i_latency_cycles  in  8  idle cycles after each full packet
i_status_rdy_stb  in  1  one-cycle request to start a transfer
i_read_size  in  32  payload words of the transfer
i_read_channel  in  CH_W  channel to drain
i_fpga2mcu_ch_rdy  in  1  FX3 can accept words
o_write_enable  out  1  word valid on o_data this cycle
o_packet_end  out  1  packet end; with o_write_enable=0 this is a ZLP
o_data  out  DATA_WIDTH  registered output word
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle pulse when the transfer completes
o_error  out  1  one-cycle pulse when a request is rejected
i_ch_ready  in  2*N_CHANNELS  ping-pong ready bits, 2 per channel
o_ch_activate  out  2*N_CHANNELS  ping-pong activate bits, 2 per channel
i_ch_size  in  24*N_CHANNELS  word count of each channel's active buffer
o_ch_strobe  out  N_CHANNELS  read strobe, one per channel
i_ch_data  in  DATA_WIDTH*N_CHANNELS  first-word-fall-through data, one word per channel

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; latched channel 0.
- Request acceptance:
  - i_status_rdy_stb in IDLE latches: channel ch; total = i_read_size + STATUS_LENGTH (33-bit, no overflow); psize = i_packet_size, or PACKET_MAX if it is 0.
  - Then go to WAIT_FOR_READY with o_busy=1.
  - Strobe outside IDLE is ignored.
  - Strobe with i_read_channel >= N_CHANNELS: o_error=1 for one cycle, stay IDLE.
- FIFO activation, latched channel only:
  - If no activate bit of ch is set and i_ch_ready of ch is nonzero, set the activate bit matching the lowest set ready bit; clear the per-buffer count.
  - When the buffer count reaches the latched i_ch_size, clear that activate bit on the next cycle.
  - Every other channel's activate and strobe outputs stay 0.
- WAIT_FOR_READY -> WRITE when i_fpga2mcu_ch_rdy && channel activate set && i_in_path_idle; the packet count clears.
- WRITE, a word is issued in a cycle only when all of these hold:
  - i_fpga2mcu_ch_rdy=1;
  - channel activate set;
  - buffer count < buffer size;
  - packet count < psize;
  - sent < total.
- On each issued word, in the same cycle:
  - o_ch_strobe[ch] asserts;
  - o_data <= the ch slice of i_ch_data and o_write_enable=1 on the next cycle (1-cycle latency);
  - sent, packet count and buffer count increment.
- Stall: if i_fpga2mcu_ch_rdy drops or the buffer empties mid-packet, no word issues; the state holds; nothing is dropped or repeated.
- o_packet_end asserts together with the last word of the transfer only when that packet is short (packet count+1 < psize). Full packets end implicitly.
- Packet count reaches psize with sent < total: go to LATENCY_HOLD, wait i_latency_cycles cycles (0 = one cycle), then go to WAIT_FOR_READY.
- sent == total:
  - If ZLP_EN and the last packet was full: go to ZLP. Wait for i_fpga2mcu_ch_rdy, then drive o_packet_end=1 with o_write_enable=0 for one cycle.
  - Then go to IDLE, o_done=1, o_busy=0, clear all activate bits.
- i_read_size=0: exactly STATUS_LENGTH words are sent.
- Reset mid-transfer: outputs 0 immediately (asynchronous); no o_done pulse.

Test Plan:
- ch1, read_size=5, psize=512, FIFO size 8 -> 8 words, one o_packet_end on word 8, o_done, ch0 strobes 0.
- ch0, read_size=13, psize=8, latency=4, ZLP_EN=1 -> two full packets of 8 with no packet_end, >=4 idle cycles between them, then a ZLP cycle.
- Same transfer with ZLP_EN=0 -> no packet_end at all.
- i_fpga2mcu_ch_rdy low for 3 cycles mid-packet -> o_write_enable gap of 3 cycles; data sequence contiguous with no duplicate.
- read_size=20 spanning two 16-word buffers -> activate toggles A then B; all 23 words in order.
- i_read_channel=3 with N_CHANNELS=2 -> o_error pulse, o_busy stays 0.
- Reset pulse mid-WRITE -> all outputs 0 asynchronously; the next request completes normally.

Source files
------------

// File: rtl/fx3_bus_out_path_mc.sv
// FX3 GPIF write path: drains one of N ping-pong FIFO channels per transfer into host packets.
// Data appears one cycle after the FIFO strobe; FX3-not-ready or an empty buffer stalls without loss.
module fx3_bus_out_path_mc #(
    parameter int DATA_WIDTH    = 32,
    parameter int N_CHANNELS    = 2,
    parameter int CH_W          = 1,
    parameter int STATUS_LENGTH = 3,
    parameter int ZLP_EN        = 1,
    parameter int PACKET_MAX    = 512
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_in_path_idle,
    input  logic [23:0]                      i_packet_size,
    input  logic [7:0]                       i_latency_cycles,
    input  logic                             i_status_rdy_stb,
    input  logic [31:0]                      i_read_size,
    input  logic [CH_W-1:0]                  i_read_channel,
    input  logic                             i_fpga2mcu_ch_rdy,
    output logic                             o_write_enable,
    output logic                             o_packet_end,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    input  logic [2*N_CHANNELS-1:0]          i_ch_ready,
    output logic [2*N_CHANNELS-1:0]          o_ch_activate,
    input  logic [24*N_CHANNELS-1:0]         i_ch_size,
    output logic [N_CHANNELS-1:0]            o_ch_strobe,
    input  logic [DATA_WIDTH*N_CHANNELS-1:0] i_ch_data
);

    localparam logic [CH_W:0] NCH_L = (CH_W+1)'(N_CHANNELS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRITE, S_LAT, S_ZLP} state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [32:0]           r_total;
    logic [32:0]           r_sent;
    logic [23:0]           r_psize;
    logic [23:0]           r_pkt_cnt;
    logic [23:0]           r_buf_cnt;
    logic [23:0]           r_buf_size;
    logic [1:0]            r_act;
    logic [7:0]            r_lat_cnt;

    logic [1:0]            w_ch_ready;
    logic [23:0]           w_ch_size;
    logic [DATA_WIDTH-1:0] w_ch_data;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_pkt_short;
    logic                  w_lat_last;

    always_comb begin
        w_ch_ready    = '0;
        w_ch_size     = '0;
        w_ch_data     = '0;
        o_ch_strobe   = '0;
        o_ch_activate = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_ch_ready             = i_ch_ready[2*c +: 2];
                w_ch_size              = i_ch_size[24*c +: 24];
                w_ch_data              = i_ch_data[DATA_WIDTH*c +: DATA_WIDTH];
                o_ch_strobe[c]         = w_issue;
                o_ch_activate[2*c +: 2] = r_act;
            end
        end
    end

    assign w_issue     = (r_state == S_WRITE) && i_fpga2mcu_ch_rdy && (r_act != 2'b00) &&
                         (r_buf_cnt < r_buf_size) && (r_pkt_cnt < r_psize) && (r_sent < r_total);
    assign w_last      = (r_sent + 33'd1) == r_total;
    assign w_pkt_short = (r_pkt_cnt + 24'd1) < r_psize;
    assign w_lat_last  = ({1'b0, r_lat_cnt} + 9'd1) >= {1'b0, i_latency_cycles};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_ch           <= '0;
            r_total        <= '0;
            r_sent         <= '0;
            r_psize        <= '0;
            r_pkt_cnt      <= '0;
            r_buf_cnt      <= '0;
            r_buf_size     <= '0;
            r_act          <= '0;
            r_lat_cnt      <= '0;
            o_write_enable <= 1'b0;
            o_packet_end   <= 1'b0;
            o_data         <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
        end else begin
            o_write_enable <= 1'b0;
            o_packet_end   <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;

            // Buffer ownership: grab the lowest ready half, hand it back once fully drained.
            if (r_state inside {S_WAIT, S_WRITE, S_LAT}) begin
                if (r_act == 2'b00) begin
                    if (w_ch_ready != 2'b00) begin
                        r_act      <= w_ch_ready[0] ? 2'b01 : 2'b10;
                        r_buf_cnt  <= '0;
                        r_buf_size <= w_ch_size;
                    end
                end else if (r_buf_cnt == r_buf_size) begin
                    r_act <= 2'b00;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_status_rdy_stb) begin
                        if ({1'b0, i_read_channel} >= NCH_L) begin
                            o_error <= 1'b1;
                        end else begin
                            r_ch      <= i_read_channel;
                            r_total   <= {1'b0, i_read_size} + 33'(STATUS_LENGTH);
                            r_psize   <= (i_packet_size == 24'd0) ? 24'(PACKET_MAX) : i_packet_size;
                            r_sent    <= '0;
                            r_pkt_cnt <= '0;
                            r_act     <= 2'b00;
                            o_busy    <= 1'b1;
                            r_state   <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_fpga2mcu_ch_rdy && (r_act != 2'b00) && i_in_path_idle) begin
                        r_pkt_cnt <= '0;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_sent == r_total) begin
                        if ((ZLP_EN != 0) && (r_pkt_cnt == r_psize)) begin
                            r_state <= S_ZLP;
                        end else begin
                            r_state <= S_IDLE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                            r_act   <= 2'b00;
                        end
                    end else if (r_pkt_cnt == r_psize) begin
                        r_lat_cnt <= '0;
                        r_state   <= S_LAT;
                    end else if (w_issue) begin
                        o_data         <= w_ch_data;
                        o_write_enable <= 1'b1;
                        o_packet_end   <= w_last && w_pkt_short;
                        r_sent         <= r_sent + 33'd1;
                        r_pkt_cnt      <= r_pkt_cnt + 24'd1;
                        r_buf_cnt      <= r_buf_cnt + 24'd1;
                    end
                end
                S_LAT: begin
                    if (w_lat_last) r_state <= S_WAIT;
                    else            r_lat_cnt <= r_lat_cnt + 8'd1;
                end
                S_ZLP: begin
                    if (i_fpga2mcu_ch_rdy) begin
                        o_packet_end <= 1'b1;
                        r_state      <= S_IDLE;
                        o_done       <= 1'b1;
                        o_busy       <= 1'b0;
                        r_act        <= 2'b00;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx3_bus_out_path_mc.sv
// Directed bench: two instances (ZLP on / off) share stimulus; a small ping-pong FIFO model feeds both.
module tb_fx3_bus_out_path_mc;
    localparam int DW = 32, NCH = 2, CHW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_idle, stb, rdy;
    logic [23:0] pkt_size;
    logic [7:0]  lat;
    logic [31:0] rsize;
    logic [CHW-1:0] rch;
    logic [2*NCH-1:0]  ch_ready;
    logic [24*NCH-1:0] ch_size;
    logic [DW*NCH-1:0] ch_data;

    logic we0, pe0, busy0, done0, err0, we1, pe1, busy1, done1, err1;
    logic [DW-1:0] data0, data1;
    logic [2*NCH-1:0] act0, act1;
    logic [NCH-1:0] strb0, strb1;

    fx3_bus_out_path_mc #(.DATA_WIDTH(DW), .N_CHANNELS(NCH), .CH_W(CHW), .STATUS_LENGTH(3),
                          .ZLP_EN(1), .PACKET_MAX(512)) dut0 (
        .clk(clk), .rst(rst), .i_in_path_idle(in_idle), .i_packet_size(pkt_size),
        .i_latency_cycles(lat), .i_status_rdy_stb(stb), .i_read_size(rsize), .i_read_channel(rch),
        .i_fpga2mcu_ch_rdy(rdy), .o_write_enable(we0), .o_packet_end(pe0), .o_data(data0),
        .o_busy(busy0), .o_done(done0), .o_error(err0), .i_ch_ready(ch_ready),
        .o_ch_activate(act0), .i_ch_size(ch_size), .o_ch_strobe(strb0), .i_ch_data(ch_data));

    fx3_bus_out_path_mc #(.DATA_WIDTH(DW), .N_CHANNELS(NCH), .CH_W(CHW), .STATUS_LENGTH(3),
                          .ZLP_EN(0), .PACKET_MAX(512)) dut1 (
        .clk(clk), .rst(rst), .i_in_path_idle(in_idle), .i_packet_size(pkt_size),
        .i_latency_cycles(lat), .i_status_rdy_stb(stb), .i_read_size(rsize), .i_read_channel(rch),
        .i_fpga2mcu_ch_rdy(rdy), .o_write_enable(we1), .o_packet_end(pe1), .o_data(data1),
        .o_busy(busy1), .o_done(done1), .o_error(err1), .i_ch_ready(ch_ready),
        .o_ch_activate(act1), .i_ch_size(ch_size), .o_ch_strobe(strb1), .i_ch_data(ch_data));

    // FIFO model: a buffer is ready while loads outnumber releases; words are {C, channel, index}.
    int idx [NCH];
    int fill [NCH][2];
    int rel [NCH][2];
    int csz [NCH];
    int strobe_cnt [NCH];
    int cyc;

    always_comb begin
        ch_ready = '0;
        ch_size  = '0;
        ch_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            ch_ready[2*c]     = (fill[c][0] != rel[c][0]);
            ch_ready[2*c+1]   = (fill[c][1] != rel[c][1]);
            ch_size[24*c +: 24] = 24'(csz[c]);
            ch_data[DW*c +: DW] = {4'hC, 4'(c), 24'(idx[c])};
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int c = 0; c < NCH; c++) begin
            if (strb0[c]) begin
                idx[c]        <= idx[c] + 1;
                strobe_cnt[c] <= strobe_cnt[c] + 1;
            end
        end
    end

    logic [DW-1:0] wq [$];
    int            wcyc [$];
    logic          wpe [$];
    int pe_we, zlp, done_cnt, err_cnt, busy_cnt, w1_cnt, pe1_cnt, done1_cnt, a_rise, b_rise;
    logic [2*NCH-1:0] prev_act = '0;

    always @(negedge clk) begin
        if (we0) begin
            wq.push_back(data0);
            wcyc.push_back(cyc);
            wpe.push_back(pe0);
        end
        if (pe0 && we0)  pe_we++;
        if (pe0 && !we0) zlp++;
        if (done0) done_cnt++;
        if (err0)  err_cnt++;
        if (busy0) busy_cnt++;
        if (we1)   w1_cnt++;
        if (pe1)   pe1_cnt++;
        if (done1) done1_cnt++;
        if (act0[2] && !prev_act[2]) a_rise = cyc;
        if (act0[3] && !prev_act[3]) b_rise = cyc;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < 2; b++)
                if (prev_act[2*c+b] && !act0[2*c+b]) rel[c][b]++;
        prev_act = act0;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int c, input int b);
        fill[c][b] = rel[c][b] + 1;
    endtask

    task automatic req(input int c, input int rs, input int ps, input int lt);
        rch = CHW'(c); rsize = 32'(rs); pkt_size = 24'(ps); lat = 8'(lt);
        stb = 1'b1;
        tick;
        stb = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != d0) break;
            tick;
        end
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_words(input int n, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (wq.size() >= n) break;
            tick;
        end
        chk(tag, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic check_seq(input int s, input int c, input int i0, input string tag);
        int mism = 0;
        for (int i = s; i < wq.size(); i++)
            if (wq[i] !== {4'hC, 4'(c), 24'(i0 + i - s)}) mism++;
        chk(tag, 32'(mism), 32'd0);
    endtask

    int s, d0, p0, z0, i0, s0, s1, e0, b0, w10, pe10, dd10, t0;

    initial begin
        in_idle = 1'b1; stb = 1'b0; rdy = 1'b1; pkt_size = '0; lat = '0; rsize = '0; rch = '0;
        repeat (3) tick;
        chk("rst_we",   32'(we0),   32'd0);
        chk("rst_pe",   32'(pe0),   32'd0);
        chk("rst_data", data0,      32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_act",  32'(act0),  32'd0);
        chk("rst_strb", 32'(strb0), 32'd0);
        rst = 1'b1;
        tick;

        // ch1, 5+3 words in one short packet of a 512-word (default) packet size
        csz[1] = 8; load(1, 0);
        s = wq.size(); d0 = done_cnt; p0 = pe_we; i0 = idx[1]; s0 = strobe_cnt[0]; s1 = strobe_cnt[1];
        req(1, 5, 0, 0);
        wait_done(d0, "t1_done");
        tick;
        chk("t1_words", 32'(wq.size() - s), 32'd8);
        check_seq(s, 1, i0, "t1_data");
        chk("t1_pe_cnt", 32'(pe_we - p0), 32'd1);
        chk("t1_pe_last", 32'(wpe[wq.size()-1]), 32'd1);
        chk("t1_ch0_strb", 32'(strobe_cnt[0] - s0), 32'd0);
        chk("t1_ch1_strb", 32'(strobe_cnt[1] - s1), 32'd8);
        chk("t1_busy", 32'(busy0), 32'd0);

        // ch0, 13+3 = two full packets of 8, latency 4, ZLP on dut0 only
        csz[0] = 32; load(0, 0);
        s = wq.size(); d0 = done_cnt; p0 = pe_we; z0 = zlp; i0 = idx[0];
        w10 = w1_cnt; pe10 = pe1_cnt; dd10 = done1_cnt;
        req(0, 13, 8, 4);
        wait_done(d0, "t2_done");
        tick;
        chk("t2_words", 32'(wq.size() - s), 32'd16);
        check_seq(s, 0, i0, "t2_data");
        chk("t2_pe_cnt", 32'(pe_we - p0), 32'd0);
        chk("t2_zlp", 32'(zlp - z0), 32'd1);
        chk("t2_gap", 32'((wq.size() >= s + 9) && (wcyc[s+8] - wcyc[s+7] >= 5)), 32'd1);
        chk("t2_nozlp_words", 32'(w1_cnt - w10), 32'd16);
        chk("t2_nozlp_pe", 32'(pe1_cnt - pe10), 32'd0);
        chk("t2_nozlp_done", 32'(done1_cnt - dd10), 32'd1);

        // FX3 not-ready for 3 cycles after word 4
        csz[0] = 16; load(0, 0);
        s = wq.size(); d0 = done_cnt; p0 = pe_we; i0 = idx[0];
        req(0, 7, 0, 0);
        wait_words(s + 4, "t3_reach4");
        rdy = 1'b0;
        repeat (3) tick;
        rdy = 1'b1;
        wait_done(d0, "t3_done");
        tick;
        chk("t3_words", 32'(wq.size() - s), 32'd10);
        check_seq(s, 0, i0, "t3_data");
        chk("t3_gap", 32'((wq.size() >= s + 5) ? (wcyc[s+4] - wcyc[s+3]) : 0), 32'd4);
        chk("t3_pe_cnt", 32'(pe_we - p0), 32'd1);

        // 20+3 words across two 16-word buffers of ch1
        csz[1] = 16; load(1, 0); load(1, 1);
        s = wq.size(); d0 = done_cnt; p0 = pe_we; i0 = idx[1]; s0 = strobe_cnt[0]; t0 = cyc;
        req(1, 20, 0, 0);
        wait_done(d0, "t4_done");
        tick;
        chk("t4_words", 32'(wq.size() - s), 32'd23);
        check_seq(s, 1, i0, "t4_data");
        chk("t4_a_first", 32'(a_rise > t0), 32'd1);
        chk("t4_b_after_a", 32'(b_rise > a_rise), 32'd1);
        chk("t4_pe_cnt", 32'(pe_we - p0), 32'd1);
        chk("t4_ch0_strb", 32'(strobe_cnt[0] - s0), 32'd0);

        // out-of-range channel
        e0 = err_cnt; b0 = busy_cnt;
        req(3, 4, 0, 0);
        repeat (4) tick;
        chk("t5_err", 32'(err_cnt - e0), 32'd1);
        chk("t5_busy", 32'(busy_cnt - b0), 32'd0);

        // async reset mid-write, then a clean transfer
        csz[0] = 64; load(0, 0);
        s = wq.size();
        req(0, 30, 0, 0);
        wait_words(s + 5, "t6_reach5");
        d0 = done_cnt;
        #2 rst = 1'b0;
        #1;
        chk("t6_we",   32'(we0),   32'd0);
        chk("t6_busy", 32'(busy0), 32'd0);
        chk("t6_act",  32'(act0),  32'd0);
        chk("t6_data", data0,      32'd0);
        chk("t6_strb", 32'(strb0), 32'd0);
        repeat (2) tick;
        rst = 1'b1;
        tick;
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        load(0, 0);
        s = wq.size(); d0 = done_cnt; p0 = pe_we; i0 = idx[0];
        req(0, 2, 0, 0);
        wait_done(d0, "t6_done");
        tick;
        chk("t6_words", 32'(wq.size() - s), 32'd5);
        check_seq(s, 0, i0, "t6_data2");
        chk("t6_pe_cnt", 32'(pe_we - p0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
